// File: rtl/aoi_bist_pkg.sv
// Shared constants, FSM state type and golden model for the AOI-3 BIST checker.
package aoi_bist_pkg;

    localparam int unsigned NUM_IN  = 10;
    localparam int unsigned NUM_VEC = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck,
        StDone
    } bist_state_e;

    // Y = ~((A&B&C) | (D&E&F) | (G&H&I) | J), A = bit 9, J = bit 0
    function automatic logic aoi3_golden(input logic [NUM_IN-1:0] v);
        return ~((v[9] & v[8] & v[7]) | (v[6] & v[5] & v[4]) | (v[3] & v[2] & v[1]) | v[0]);
    endfunction

endpackage

// File: rtl/aoi_3_golden.sv
// Combinational reference model of the AOI-3 gate; kept separate so it can be swapped.
module aoi_3_golden
    import aoi_bist_pkg::*;
(
    input  logic [NUM_IN-1:0] vec,
    output logic              y
);

    // Reference output for the vector currently applied
    always_comb begin
        y = aoi3_golden(vec);
    end

endmodule

// File: rtl/aoi_3_bist_checker.sv
// Exhaustive sweep of the AOI-3 gate with settle delay, golden compare, error count and
// first-failure capture.
module aoi_3_bist_checker
    import aoi_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [NUM_IN-1:0] dut_in,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [NUM_IN-1:0] first_fail_vec,
    output logic              first_fail_valid
);

    localparam logic [NUM_IN-1:0] LastVec   = NUM_IN'(NUM_VEC - 1);
    localparam logic [3:0]        SettleLd  = 4'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  ErrMax    = '1;

    bist_state_e       state_q, state_d;
    logic [NUM_IN-1:0] vec_q, vec_d;
    logic [3:0]        settle_q, settle_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [NUM_IN-1:0] ffv_q, ffv_d;
    logic              ffvalid_q, ffvalid_d;
    logic              pass_q, pass_d;
    logic              golden_y;

    aoi_3_golden u_golden (
        .vec (vec_q),
        .y   (golden_y)
    );

    // State and statistics registers; reset clears every result immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            vec_q     <= '0;
            settle_q  <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            settle_q  <= settle_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            pass_q    <= pass_d;
        end
    end

    // Next-state logic: sweep sequencing, compare, saturating count and capture
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        pass_d    = pass_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StDrive;
                    vec_d     = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            StDrive: begin
                settle_d = SettleLd;
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == 4'd0) begin
                    state_d = StCheck;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StCheck: begin
                if (dut_y != golden_y) begin
                    if (err_q != ErrMax) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (vec_q == LastVec) begin
                    state_d = StDone;
                    // Uses the updated count so a failure on the last vector is reflected
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + NUM_IN'(1);
                    state_d = StDrive;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        dut_in           = vec_q;
        busy             = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
        done             = (state_q == StDone);
        pass             = pass_q;
        err_cnt          = err_q;
        first_fail_vec   = ffv_q;
        first_fail_valid = ffvalid_q;
    end

endmodule

// File: tb/tb_aoi_3_bist_checker.sv
// Directed bench for aoi_3_bist_checker: three instances cover default, narrow counter
// and long settle configurations.
module tb_aoi_3_bist_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Gate behaviour per instance: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted
    int mode_a, mode_b, mode_c;

    logic       start_a, start_b, start_c;
    logic [9:0] in_a, in_b, in_c;
    logic       y_a, y_b, y_c;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [15:0] err_a, err_c;
    logic [7:0]  err_b;
    logic [9:0]  ffv_a, ffv_b, ffv_c;
    logic        ffok_a, ffok_b, ffok_c;

    int total = 0;
    int bad   = 0;

    function automatic logic gate_ref(input logic [9:0] v);
        logic t1, t2, t3;
        t1 = v[9] & v[8] & v[7];
        t2 = v[6] & v[5] & v[4];
        t3 = v[3] & v[2] & v[1];
        return !(t1 || t2 || t3 || v[0]);
    endfunction

    function automatic logic gate_out(input int mode, input logic [9:0] v);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~gate_ref(v);
            default: return gate_ref(v);
        endcase
    endfunction

    assign y_a = gate_out(mode_a, in_a);
    assign y_b = gate_out(mode_b, in_b);
    assign y_c = gate_out(mode_c, in_c);

    aoi_3_bist_checker #(.SETTLE_CYC(2), .CNT_W(16)) u_a (
        .clk (clk), .rst (rst), .start (start_a), .dut_in (in_a), .dut_y (y_a),
        .busy (busy_a), .done (done_a), .pass (pass_a), .err_cnt (err_a),
        .first_fail_vec (ffv_a), .first_fail_valid (ffok_a)
    );

    aoi_3_bist_checker #(.SETTLE_CYC(2), .CNT_W(8)) u_b (
        .clk (clk), .rst (rst), .start (start_b), .dut_in (in_b), .dut_y (y_b),
        .busy (busy_b), .done (done_b), .pass (pass_b), .err_cnt (err_b),
        .first_fail_vec (ffv_b), .first_fail_valid (ffok_b)
    );

    aoi_3_bist_checker #(.SETTLE_CYC(5), .CNT_W(16)) u_c (
        .clk (clk), .rst (rst), .start (start_c), .dut_in (in_c), .dut_y (y_c),
        .busy (busy_c), .done (done_c), .pass (pass_c), .err_cnt (err_c),
        .first_fail_vec (ffv_c), .first_fail_valid (ffok_c)
    );

    function automatic logic done_of(input int idx);
        case (idx)
            1:       return done_b;
            2:       return done_c;
            default: return done_a;
        endcase
    endfunction

    // One-cycle start pulse; returns #1 after the edge that samples it
    task automatic kick(input int idx);
        @(posedge clk); #1;
        case (idx)
            1:       start_b = 1'b1;
            2:       start_c = 1'b1;
            default: start_a = 1'b1;
        endcase
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    // Counts edges after the start edge until done; bounded by limit
    task automatic wait_done(input int idx, input int limit, output int n);
        n = 0;
        while (!done_of(idx) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        total++;
        if ({busy_a, done_a, pass_a, err_a, ffv_a, ffok_a, in_a} !== '0) begin
            bad++; $display("FAIL reset_a: got busy=%b done=%b pass=%b err=%0d ffv=%h ffok=%b in=%h want all 0",
                            busy_a, done_a, pass_a, err_a, ffv_a, ffok_a, in_a);
        end
        total++;
        if ({busy_b, done_b, err_b, ffok_b, busy_c, done_c, err_c, ffok_c} !== '0) begin
            bad++; $display("FAIL reset_bc: got busy_b=%b done_b=%b err_b=%0d busy_c=%b err_c=%0d want 0",
                            busy_b, done_b, err_b, busy_c, err_c);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_good_sweep;
        int n;
        mode_a = 0;
        kick(0);
        total++;
        if (busy_a !== 1'b1 || done_a !== 1'b0) begin
            bad++; $display("FAIL good_busy_rise: got busy=%b done=%b want 1 0", busy_a, done_a);
        end
        wait_done(0, 5000, n);
        total++;
        if (n !== 4096) begin
            bad++; $display("FAIL good_latency: got %0d cycles want 4096", n);
        end
        total++;
        if (busy_a !== 1'b0 || pass_a !== 1'b1 || err_a !== 16'd0 || ffok_a !== 1'b0) begin
            bad++; $display("FAIL good_result: got busy=%b pass=%b err=%0d ffok=%b want 0 1 0 0",
                            busy_a, pass_a, err_a, ffok_a);
        end
    endtask

    task automatic test_stuck(input int mode, input int exp_err, input logic [9:0] exp_vec);
        int n;
        mode_a = mode;
        kick(0);
        wait_done(0, 5000, n);
        total++;
        if (n !== 4096 || done_a !== 1'b1) begin
            bad++; $display("FAIL stuck%0d_latency: got %0d done=%b want 4096 1", mode, n, done_a);
        end
        total++;
        if (err_a !== 16'(exp_err)) begin
            bad++; $display("FAIL stuck%0d_err: got %0d want %0d", mode, err_a, exp_err);
        end
        total++;
        if (ffv_a !== exp_vec || ffok_a !== 1'b1 || pass_a !== 1'b0) begin
            bad++; $display("FAIL stuck%0d_capture: got ffv=%h ffok=%b pass=%b want %h 1 0",
                            mode, ffv_a, ffok_a, pass_a, exp_vec);
        end
    endtask

    task automatic test_saturate;
        int n;
        mode_b = 3;
        kick(1);
        wait_done(1, 5000, n);
        total++;
        if (n !== 4096) begin
            bad++; $display("FAIL sat_latency: got %0d want 4096", n);
        end
        total++;
        if (err_b !== 8'hff || ffv_b !== 10'h000 || ffok_b !== 1'b1 || pass_b !== 1'b0) begin
            bad++; $display("FAIL sat_result: got err=%0d ffv=%h ffok=%b pass=%b want 255 000 1 0",
                            err_b, ffv_b, ffok_b, pass_b);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        int guard;
        mode_a = 1;
        kick(0);
        guard = 0;
        while (in_a !== 10'd500 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (in_a !== 10'd500) begin
            bad++; $display("FAIL midrst_reach: got vec %0d want 500", in_a);
        end
        total++;
        if (err_a === 16'd0 || ffok_a !== 1'b1) begin
            bad++; $display("FAIL midrst_pre: got err=%0d ffok=%b want nonzero 1", err_a, ffok_a);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy_a, done_a, pass_a, err_a, ffv_a, ffok_a, in_a} !== '0) begin
            bad++; $display("FAIL midrst_async: got busy=%b done=%b err=%0d ffv=%h ffok=%b in=%h want 0",
                            busy_a, done_a, err_a, ffv_a, ffok_a, in_a);
        end
        @(negedge clk) rst = 1'b0;
        mode_a = 0;
        kick(0);
        wait_done(0, 5000, n);
        total++;
        if (n !== 4096 || pass_a !== 1'b1 || err_a !== 16'd0) begin
            bad++; $display("FAIL midrst_rerun: got cycles=%0d pass=%b err=%0d want 4096 1 0",
                            n, pass_a, err_a);
        end
    endtask

    task automatic test_start_ignored;
        int n;
        logic busy_ok;
        mode_a = 2;
        kick(0);
        n = 0;
        busy_ok = 1'b1;
        while (!done_a && n < 5000) begin
            start_a = (n == 100 || n == 2000 || n == 4000 || n == 4094);
            @(posedge clk); #1;
            n++;
            if (!done_a && busy_a !== 1'b1) busy_ok = 1'b0;
        end
        start_a = 1'b0;
        total++;
        if (n !== 4096 || busy_ok !== 1'b1) begin
            bad++; $display("FAIL ignore_latency: got cycles=%0d busy_held=%b want 4096 1", n, busy_ok);
        end
        total++;
        if (err_a !== 16'd681 || ffv_a !== 10'h001) begin
            bad++; $display("FAIL ignore_result: got err=%0d ffv=%h want 681 001", err_a, ffv_a);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        mode_c = 1;
        kick(2);
        wait_done(2, 9000, n);
        total++;
        if (n !== 7168 || err_c !== 16'd343 || ffok_c !== 1'b1) begin
            bad++; $display("FAIL s5_first: got cycles=%0d err=%0d ffok=%b want 7168 343 1",
                            n, err_c, ffok_c);
        end
        mode_c = 0;
        kick(2);
        total++;
        if (busy_c !== 1'b1 || done_c !== 1'b0 || err_c !== 16'd0 || ffok_c !== 1'b0 ||
            pass_c !== 1'b0) begin
            bad++; $display("FAIL s5_restart_clear: got busy=%b done=%b err=%0d ffok=%b pass=%b want 1 0 0 0 0",
                            busy_c, done_c, err_c, ffok_c, pass_c);
        end
        wait_done(2, 9000, n);
        total++;
        if (n !== 7168 || pass_c !== 1'b1 || err_c !== 16'd0) begin
            bad++; $display("FAIL s5_second: got cycles=%0d pass=%b err=%0d want 7168 1 0",
                            n, pass_c, err_c);
        end
    endtask

    initial begin
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mode_a = 0; mode_b = 0; mode_c = 0;
        test_reset();
        test_good_sweep();
        test_stuck(1, 343, 10'h000);
        test_stuck(2, 681, 10'h001);
        test_saturate();
        test_reset_mid_sweep();
        test_start_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
